// File: rtl/act_stream_seq.sv
// -----------------------------------------------------------------------------
// act_stream_seq
//
// Downstream sequencer for the temporary activation BRAM. On start_i it walks
// BRAM indices 0..MAC_CNT-1 and absorbs the BRAM's one-cycle read latency with
// a two-entry {data, index} FIFO. The FIFO head is streamed to the next layer
// under valid/ready flow control. When the last entry has been accepted, the
// block pulses clear_o and done_o together, then returns to idle.
//
// Optional feature macro: ACT_STREAM_RELU_EN
//   defined     -> negative captured activations (MSB set) become zero at push
//   not defined -> activations pass through bit-exact
//
// Ports
//   clk_i              clock, all state on the rising edge
//   rstn_i             asynchronous active-low reset
//   start_i            one-cycle pulse, BRAM loaded; ignored unless idle
//   rd_temp_en_o       BRAM read enable
//   temp_bram_index_o  BRAM read index
//   temp_data_i        BRAM data_out, valid the cycle after rd_temp_en_o
//   clear_o            one-cycle BRAM clear pulse at end of pass
//   act_o              streamed activation
//   act_index_o        index of act_o
//   act_valid_o        act_o valid
//   act_last_o         act_o carries index MAC_CNT-1
//   ready_i            downstream accepts act_o this cycle
//   busy_o             sequencer not idle
//   done_o             one-cycle pulse, pass complete
// -----------------------------------------------------------------------------
module act_stream_seq #(
    parameter int MAC_CNT    = 128,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(MAC_CNT)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    output logic                  rd_temp_en_o,
    output logic [ADDR_WIDTH-1:0] temp_bram_index_o,
    input  logic [DATA_WIDTH-1:0] temp_data_i,
    output logic                  clear_o,
    output logic [DATA_WIDTH-1:0] act_o,
    output logic [ADDR_WIDTH-1:0] act_index_o,
    output logic                  act_valid_o,
    output logic                  act_last_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MAC_CNT - 1);

    // Shapes captured BRAM data before it enters the FIFO.
    function automatic logic [DATA_WIDTH-1:0] shape_data(input logic [DATA_WIDTH-1:0] d);
`ifdef ACT_STREAM_RELU_EN
        return d[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : d;
`else
        return d;
`endif
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_idx_q, inflight_idx_d;
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [ADDR_WIDTH-1:0] head_idx_q, head_idx_d;
    logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
    logic [ADDR_WIDTH-1:0] tail_idx_q, tail_idx_d;
    logic [1:0]            count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  clear_q, clear_d;

    logic                  pop_s;
    logic                  push_s;
    logic [2:0]            occ_s;
    logic                  rd_en_s;
    logic [DATA_WIDTH-1:0] push_data_s;

    // Read issue: allowed only while streaming and when the FIFO plus the read
    // already in flight, net of this cycle's pop, leaves room for one more.
    always_comb begin
        pop_s       = (count_q != 2'd0) & ready_i;
        push_s      = rd_inflight_q;
        push_data_s = shape_data(temp_data_i);
        occ_s       = {1'b0, count_q} + {2'b00, rd_inflight_q} - {2'b00, pop_s};
        rd_en_s     = (state_q == ST_STREAM) && (occ_s < 3'd2);
    end

    // Two-entry FIFO: head feeds the stream outputs, tail buffers one more.
    always_comb begin
        head_data_d    = head_data_q;
        head_idx_d     = head_idx_q;
        tail_data_d    = tail_data_q;
        tail_idx_d     = tail_idx_q;
        count_d        = count_q;
        rd_inflight_d  = rd_en_s;
        inflight_idx_d = rd_en_s ? rd_idx_q : inflight_idx_q;
        case ({push_s, pop_s})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_data_d = push_data_s;
                    head_idx_d  = inflight_idx_q;
                end else begin
                    tail_data_d = push_data_s;
                    tail_idx_d  = inflight_idx_q;
                end
            end
            2'b01: begin
                count_d     = count_q - 2'd1;
                head_data_d = tail_data_q;
                head_idx_d  = tail_idx_q;
            end
            2'b11: begin
                // Occupancy unchanged; the new entry lands behind what remains.
                if (count_q == 2'd1) begin
                    head_data_d = push_data_s;
                    head_idx_d  = inflight_idx_q;
                end else begin
                    head_data_d = tail_data_q;
                    head_idx_d  = tail_idx_q;
                    tail_data_d = push_data_s;
                    tail_idx_d  = inflight_idx_q;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Pass sequencing and read index counter.
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_STREAM;
                    rd_idx_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (rd_en_s) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_idx_d = rd_idx_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                // Look at next-cycle occupancy so the clear lands right after
                // the final beat is accepted.
                if ((count_d == 2'd0) && !rd_inflight_d) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                state_d  = ST_IDLE;
                rd_idx_d = {ADDR_WIDTH{1'b0}};
            end
            default: begin
                state_d  = ST_IDLE;
                rd_idx_d = {ADDR_WIDTH{1'b0}};
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_CLEAR);
        clear_d = (state_d == ST_CLEAR);
    end

    // State, FIFO and status registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= ST_IDLE;
            rd_idx_q       <= {ADDR_WIDTH{1'b0}};
            rd_inflight_q  <= 1'b0;
            inflight_idx_q <= {ADDR_WIDTH{1'b0}};
            head_data_q    <= {DATA_WIDTH{1'b0}};
            head_idx_q     <= {ADDR_WIDTH{1'b0}};
            tail_data_q    <= {DATA_WIDTH{1'b0}};
            tail_idx_q     <= {ADDR_WIDTH{1'b0}};
            count_q        <= 2'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            clear_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_idx_q       <= rd_idx_d;
            rd_inflight_q  <= rd_inflight_d;
            inflight_idx_q <= inflight_idx_d;
            head_data_q    <= head_data_d;
            head_idx_q     <= head_idx_d;
            tail_data_q    <= tail_data_d;
            tail_idx_q     <= tail_idx_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            clear_q        <= clear_d;
        end
    end

    // Output mapping; read enable depends on this cycle's pop so it stays
    // combinational to keep one read per cycle under continuous ready.
    always_comb begin
        rd_temp_en_o      = rd_en_s;
        temp_bram_index_o = rd_idx_q;
        act_o             = head_data_q;
        act_index_o       = head_idx_q;
        act_valid_o       = (count_q != 2'd0);
        act_last_o        = (count_q != 2'd0) && (head_idx_q == LAST_IDX);
        busy_o            = busy_q;
        done_o            = done_q;
        clear_o           = clear_q;
    end

endmodule

// File: tb/tb_act_stream_seq.sv
module tb_act_stream_seq;

    logic       clk = 1'b0;
    logic       rstn_s;
    int         vectors = 0;
    int         miscompares = 0;
    int         beats = 0;

    // Small instance, MAC_CNT = 4
    logic       start_s, ready_s, rd_en_s, clear_s, valid_s, last_s, busy_s, done_s;
    logic [1:0] bidx_s, aidx_s;
    logic [7:0] tdata_s, act_s;
    logic [7:0] mem_s [4];

    // Large instance, MAC_CNT = 128
    logic       start_b, ready_b, rd_en_b, clear_b, valid_b, last_b, busy_b, done_b;
    logic [6:0] bidx_b, aidx_b;
    logic [7:0] tdata_b, act_b;
    logic [6:0] big_idx = 7'd0;

    logic [9:0] exp_q [$];
    logic       hold_pend = 1'b0;
    logic [7:0] hold_act  = 8'h00;
    logic [1:0] hold_idx  = 2'd0;

    always #5 clk = ~clk;

    act_stream_seq #(.MAC_CNT(4), .DATA_WIDTH(8)) u_dut (
        .clk_i(clk), .rstn_i(rstn_s), .start_i(start_s),
        .rd_temp_en_o(rd_en_s), .temp_bram_index_o(bidx_s), .temp_data_i(tdata_s),
        .clear_o(clear_s), .act_o(act_s), .act_index_o(aidx_s), .act_valid_o(valid_s),
        .act_last_o(last_s), .ready_i(ready_s), .busy_o(busy_s), .done_o(done_s)
    );

    act_stream_seq #(.MAC_CNT(128), .DATA_WIDTH(8)) u_dut_big (
        .clk_i(clk), .rstn_i(rstn_s), .start_i(start_b),
        .rd_temp_en_o(rd_en_b), .temp_bram_index_o(bidx_b), .temp_data_i(tdata_b),
        .clear_o(clear_b), .act_o(act_b), .act_index_o(aidx_b), .act_valid_o(valid_b),
        .act_last_o(last_b), .ready_i(ready_b), .busy_o(busy_b), .done_o(done_b)
    );

    // BRAM models: one-cycle read latency, zero output on non-read cycles.
    always @(posedge clk or negedge rstn_s) begin
        if (!rstn_s) begin
            tdata_s <= 8'h00;
            tdata_b <= 8'h00;
        end else begin
            tdata_s <= rd_en_s ? mem_s[bidx_s] : 8'h00;
            tdata_b <= rd_en_b ? {1'b0, bidx_b} : 8'h00;
        end
    end

    function automatic logic [7:0] exp_act(input logic [7:0] d);
`ifdef ACT_STREAM_RELU_EN
        return d[7] ? 8'h00 : d;
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small-instance monitor: scoreboard compare on accepted beats, and
    // stability of a stalled head.
    always @(negedge clk) begin
        logic [9:0] e;
        if (hold_pend && rstn_s) begin
            check("hold_valid", 32'(valid_s), 32'd1);
            check("hold_act", 32'(act_s), 32'(hold_act));
            check("hold_idx", 32'(aidx_s), 32'(hold_idx));
        end
        hold_pend <= valid_s && !ready_s && rstn_s;
        hold_act  <= act_s;
        hold_idx  <= aidx_s;
        if (valid_s && ready_s) begin
            beats++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_idx", 32'(aidx_s), 32'(e[9:8]));
                check("beat_act", 32'(act_s), 32'(e[7:0]));
                check("beat_last", 32'(last_s), 32'(e[9:8] == 2'd3));
            end
        end
    end

    // Large-instance monitor: indices must run 0..127 in order, repeatedly.
    always @(negedge clk) begin
        if (valid_b && ready_b) begin
            check("big_idx", 32'(aidx_b), 32'(big_idx));
            check("big_act", 32'(act_b), 32'(exp_act({1'b0, big_idx})));
            check("big_last", 32'(last_b), 32'(big_idx == 7'd127));
            big_idx <= big_idx + 7'd1;
        end
    end

    // One small-instance pass driven from per-cycle masks (bit c = cycle c,
    // cycle 0 being the first start_i cycle).
    task automatic run_small(input string tag, input int ncyc,
                             input logic [31:0] start_m, input logic [31:0] ready_m,
                             input logic [31:0] rst_m, input logic [31:0] rd_m,
                             input logic [31:0] valid_m, input logic [31:0] busy_m,
                             input int done_c, input int n_beats);
        int rd_cnt;
        int b0;
        rd_cnt = 0;
        b0 = beats;
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), exp_act(mem_s[i])});
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start_s = start_m[c];
            ready_s = ready_m[c];
            rstn_s  = !rst_m[c];
            @(negedge clk);
            check({tag, "_rd_en"}, 32'(rd_en_s), 32'(rd_m[c]));
            if (rd_m[c]) begin
                check({tag, "_rd_idx"}, 32'(bidx_s), 32'(rd_cnt));
                rd_cnt++;
            end
            check({tag, "_valid"}, 32'(valid_s), 32'(valid_m[c]));
            check({tag, "_busy"}, 32'(busy_s), 32'(busy_m[c]));
            check({tag, "_done"}, 32'(done_s), 32'(c == done_c));
            check({tag, "_clear"}, 32'(clear_s), 32'(c == done_c));
            if (rst_m[c]) begin
                check({tag, "_rst_outs"},
                      32'({rd_en_s, bidx_s, clear_s, act_s, aidx_s, valid_s, last_s, busy_s, done_s}),
                      32'd0);
            end
        end
        rstn_s = 1'b1;
        check({tag, "_beats"}, 32'(beats - b0), 32'(n_beats));
        check({tag, "_sb_left"}, 32'(exp_q.size()), 32'(4 - n_beats));
        exp_q.delete();
    endtask

    initial begin
        mem_s[0] = 8'd5;
        mem_s[1] = 8'hFD;
        mem_s[2] = 8'd7;
        mem_s[3] = 8'd0;
        rstn_s  = 1'b0;
        start_s = 1'b0;
        ready_s = 1'b1;
        start_b = 1'b0;
        ready_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_small",
              32'({rd_en_s, bidx_s, clear_s, act_s, aidx_s, valid_s, last_s, busy_s, done_s}), 32'd0);
        check("reset_big",
              32'({rd_en_b, bidx_b, clear_b, act_b, aidx_b, valid_b, last_b, busy_b, done_b}), 32'd0);
        @(posedge clk);
        #1;
        rstn_s = 1'b1;
        repeat (2) @(posedge clk);

        // Continuous ready
        run_small("s1", 10, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1E, 32'h78, 32'hFE, 7, 4);
        // ready 1,0,1,0 over the first four valid cycles
        run_small("s2", 12, 32'h1, 32'hFFFF_FFAF, 32'h0, 32'h2E, 32'h1F8, 32'h3FE, 9, 4);
        // ready low for 10 cycles after start
        run_small("s3", 16, 32'h1, 32'hFFFF_FC00, 32'h0, 32'hC06, 32'h3FF8, 32'h7FFE, 14, 4);
        // start re-pulsed at cycle 2 is ignored
        run_small("s4", 10, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h1E, 32'h78, 32'hFE, 7, 4);
        // reset at cycle 4 aborts the pass
        run_small("s5", 12, 32'h1, 32'hFFFF_FFFF, 32'h30, 32'h0E, 32'h08, 32'h0E, -1, 1);
        // clean pass after the abort
        run_small("s6", 10, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h1E, 32'h78, 32'hFE, 7, 4);

        // Two back-to-back MAC_CNT=128 passes
        for (int c = 0; c < 266; c++) begin
            @(posedge clk);
            #1;
            start_b = (c == 0) || (c == 132);
            @(negedge clk);
            check("big_valid", 32'(valid_b),
                  32'(((c >= 3) && (c <= 130)) || ((c >= 135) && (c <= 262))));
            check("big_busy", 32'(busy_b),
                  32'(((c >= 1) && (c <= 131)) || ((c >= 133) && (c <= 263))));
            check("big_done", 32'(done_b), 32'((c == 131) || (c == 263)));
            check("big_clear", 32'(clear_b), 32'((c == 131) || (c == 263)));
        end
        check("big_idx_end", 32'(big_idx), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/act_stream_seq.md
# act_stream_seq

Downstream sequencer for the temporary activation BRAM. After a layer's MAC outputs are written into the BRAM, it walks indices 0..MAC_CNT-1 and absorbs the BRAM's 1-cycle read latency. It streams each activation, with valid/ready flow control, to the next layer's broadcast input, then clears the BRAM and reports completion.

## Interface
- MAC_CNT, 128, number of stored activations (entries walked per pass)
- DATA_WIDTH, 8, activation width (two's complement)
- ADDR_WIDTH, $clog2(MAC_CNT), BRAM index width
- clk_i  input  1  clock; all state on rising edge
- rstn_i  input  1  reset, asynchronous, active-low
- start_i  input  1  one-cycle pulse: BRAM loaded, begin pass; ignored unless IDLE
- rd_temp_en_o  output  1  BRAM read enable
- temp_bram_index_o  output  ADDR_WIDTH  BRAM read index
- temp_data_i  input  DATA_WIDTH  BRAM data_out, valid the cycle after rd_temp_en_o
- clear_o  output  1  one-cycle BRAM clear pulse at end of pass
- act_o  output  DATA_WIDTH  streamed activation
- act_index_o  output  ADDR_WIDTH  index of act_o
- act_valid_o  output  1  act_o valid
- act_last_o  output  1  act_o is index MAC_CNT-1 (qualified by act_valid_o)
- ready_i  input  1  downstream accepts act_o this cycle
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle pulse, pass complete

## Operation
- FSM: IDLE -> STREAM on start_i; STREAM -> DRAIN after read of index MAC_CNT-1 issued; DRAIN -> CLEAR when FIFO empty and no read in flight; CLEAR -> IDLE unconditionally.
- Read index counter: ADDR_WIDTH bits, 0 on entering STREAM, +1 per issued read, no wrap; last read is MAC_CNT-1.
- rd_inflight: register = rd_temp_en_o of previous cycle. The index travels with it in a parallel register.
- Output FIFO: 2 entries of {data, index}. Push when rd_inflight, capturing temp_data_i. Pop when act_valid_o & ready_i. The head drives act_o/act_index_o/act_valid_o.
- Issue rule in STREAM: rd_temp_en_o = 1 iff (fifo_count + rd_inflight - pop) < 2. This gives one read per cycle while ready_i is held high, and the FIFO never overflows.
- The BRAM zeroes data_out on non-read cycles. temp_data_i is sampled only when rd_inflight.
- Reads are never issued outside STREAM. clear_o is asserted only in CLEAR, so it never coincides with a read.
- done_o and clear_o are both asserted in the CLEAR cycle.
- start_i while busy_o is dropped, with no effect.
- act_valid_o, once high, holds act_o/act_index_o stable until accepted.

## Timing
- Reset values: rd_temp_en_o, temp_bram_index_o, clear_o, act_o, act_index_o, act_valid_o, act_last_o, busy_o, done_o all 0; FSM IDLE; FIFO empty; rd_inflight 0.
- Reset mid-pass: immediate abort to the reset values. No clear_o or done_o is generated.
- start_i at cycle 0: STREAM and first read (index 0) at cycle 1; BRAM data at cycle 2; act_valid_o at cycle 3.
- ready_i held high: one activation per cycle, indices 0..MAC_CNT-1 on cycles 3..MAC_CNT+2. clear_o/done_o at cycle MAC_CNT+3. busy_o is high for cycles 1..MAC_CNT+3.
- Each cycle ready_i is low while act_valid_o is high delays the completion point by one cycle. Order is preserved and no entry is lost or duplicated.
- ready_i low from start: reads stop after 2 issued; FIFO full; rd_temp_en_o stays 0 until a pop.

## Configuration
- ACT_STREAM_RELU_EN defined: act_o = 0 when captured data is negative (MSB set), otherwise unchanged. ReLU is applied at FIFO push.
- Not defined: act_o is temp_data_i passed through bit-exact.

## Test plan
- MAC_CNT=4, BRAM holds {5,-3,7,0}, ready_i=1, start_i at cycle 0 -> act_valid_o cycles 3-6, indices 0,1,2,3 with act_last_o at cycle 6, clear_o=done_o=1 at cycle 7, busy_o cycles 1-7. act_o is {5,0,7,0} with ACT_STREAM_RELU_EN, {5,-3,7,0} without.
- Same data, ready_i toggling 1,0,1,0 -> exactly 4 accepted beats in index order. No rd_temp_en_o while FIFO count + inflight = 2. done_o arrives 2 cycles later than in the first scenario.
- ready_i=0 for 10 cycles after start -> exactly 2 reads (indices 0,1), act_o=5 held stable. After ready_i=1, the remaining beats stream out.
- start_i pulsed at cycle 2 of an active pass -> ignored; still exactly MAC_CNT beats and one done_o.
- rstn_i low at cycle 4 of a pass -> all outputs 0 next cycle, no clear_o/done_o. A later start_i runs a full clean pass from index 0.
- MAC_CNT=128 back-to-back passes, ready_i=1 -> each pass takes 132 cycles start-to-done, with indices 0..127 and no gaps.
